pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline.
- Drives the EN/flush controls of the IF_ID, ID_EX and EX_MEM pipe interfaces, plus the MEM_WB enable and the PC write enable.
- Resolves cache waits, load-use hazards, EX-stage redirects (branch/jump) and halt drain.
- A small FSM tracks outstanding data-cache waits and the terminal halt condition.

---
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage MIPS pipeline.
// Generates the pipe-register enables and flushes plus the PC write enable from
// cache-wait, load-use, EX-redirect and halt conditions. A three-state FSM
// (RUN / DWAIT / HALT) tracks an outstanding data-cache access and the final
// halt. Control outputs are Mealy: combinational from state and inputs.
// Optional build macro: PIPE_CTRL_PERF_EN adds stall/flush performance counters;
// without it stall_cnt and flush_cnt are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_rt_used,
  input  logic             idex_dREN,
  input  logic [REG_W-1:0] idex_wsel,
  input  logic             ex_redirect,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DWAIT = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       halt_reg;
  logic       halt_set;
  logic       dreq;
  logic       mem_stall;
  logic       stall_now;
  logic       lu;

  // Hazard terms; in DWAIT the stall is held purely by the missing dhit.
  always_comb begin
    dreq      = exmem_dREN | exmem_dWEN;
    mem_stall = dreq & ~dhit;
    lu        = idex_dREN & (idex_wsel != {REG_W{1'b0}}) &
                ((idex_wsel == ifid_rs) | (ifid_rt_used & (idex_wsel == ifid_rt)));
    if (state == ST_DWAIT) begin
      stall_now = ~dhit;
    end else begin
      stall_now = mem_stall;
    end
  end

  // Prioritised control decode and next-state selection.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halt_set    = 1'b0;
    state_next  = state;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state)
        ST_RUN, ST_DWAIT: begin
          if (exmem_halt) begin
            // Drain the last instruction into write-back, then freeze.
            memwb_en   = 1'b1;
            halt_set   = 1'b1;
            state_next = ST_HALT;
          end else if (stall_now) begin
            state_next = ST_DWAIT;
          end else begin
            state_next = ST_RUN;
            if (ex_redirect) begin
              // Redirect beats load-use: the ID instruction is squashed anyway.
              pc_en      = 1'b1;
              ifid_en    = 1'b1;
              ifid_flush = 1'b1;
              idex_en    = 1'b1;
              idex_flush = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
            end else if (lu) begin
              // Hold IF/ID and PC, inject a single bubble into ID/EX.
              idex_en    = 1'b1;
              idex_flush = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
            end else if (~ihit) begin
              // Fetch not ready: bubble into IF/ID, keep downstream moving.
              ifid_en    = 1'b1;
              ifid_flush = 1'b1;
              idex_en    = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
            end else begin
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
            end
          end
        end
        ST_HALT: begin
          state_next = ST_HALT;
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // FSM state and sticky halt flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_RUN;
      halt_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (halt_set) begin
        halt_reg <= 1'b1;
      end else begin
        halt_reg <= halt_reg;
      end
    end
  end

  assign halt = halt_reg;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Performance counters: stalled cycles outside HALT, and IF/ID flushes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= {CNT_W{1'b0}};
      flush_q <= {CNT_W{1'b0}};
    end else begin
      if (~pc_en && (state != ST_HALT)) begin
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_q <= stall_q;
      end
      if (ifid_flush) begin
        flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_q <= flush_q;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed steps followed by randomized
// cycles, each checked against an action-level reference model.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, ifid_rt_used, idex_dREN, ex_redirect;
  logic        exmem_dREN, exmem_dWEN, exmem_halt;
  logic [4:0]  ifid_rs, ifid_rt, idex_wsel;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, halt;
  logic [31:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic        m_wait = 1'b0;
  logic        m_halt = 1'b0;
  logic [31:0] m_scnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;

  localparam int A_RESET  = 0;
  localparam int A_HALTED = 1;
  localparam int A_HALT   = 2;
  localparam int A_STALL  = 3;
  localparam int A_REDIR  = 4;
  localparam int A_LU     = 5;
  localparam int A_IFB    = 6;
  localparam int A_NORM   = 7;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rt_used(ifid_rt_used),
    .idex_dREN(idex_dREN), .idex_wsel(idex_wsel), .ex_redirect(ex_redirect),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Which rule applies this cycle, decided straight from the rule list.
  function automatic int model_action();
    logic uses_dst;
    logic waiting_mem;
    if (RST) return A_RESET;
    if (m_halt) return A_HALTED;
    if (exmem_halt) return A_HALT;
    waiting_mem = m_wait ? !dhit : ((exmem_dREN || exmem_dWEN) && !dhit);
    if (waiting_mem) return A_STALL;
    if (ex_redirect) return A_REDIR;
    uses_dst = (idex_wsel == ifid_rs) || (ifid_rt_used && idex_wsel == ifid_rt);
    if (idex_dREN && idex_wsel != 5'd0 && uses_dst) return A_LU;
    if (!ihit) return A_IFB;
    return A_NORM;
  endfunction

  // Control vector {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb}.
  function automatic logic [7:0] action_vec(input int a);
    case (a)
      A_RESET: return 8'b0010_1010;
      A_HALT:  return 8'b0000_0001;
      A_REDIR: return 8'b1111_1101;
      A_LU:    return 8'b0001_1101;
      A_IFB:   return 8'b0111_0101;
      A_NORM:  return 8'b1101_0101;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic step();
    int          act;
    logic [7:0]  exp_v;
    logic [7:0]  obs_v;
    logic [31:0] exp_s;
    logic [31:0] exp_f;
    @(negedge CLK);
    act   = model_action();
    exp_v = action_vec(act);
    obs_v = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};
`ifdef PIPE_CTRL_PERF_EN
    exp_s = m_scnt;
    exp_f = m_fcnt;
`else
    exp_s = 32'd0;
    exp_f = 32'd0;
`endif
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL ctrl vec=%0d: observed %b expected %b", n_vec, obs_v, exp_v);
    end
    assert (halt === m_halt) else begin
      n_err++;
      $error("FAIL halt vec=%0d: observed %b expected %b", n_vec, halt, m_halt);
    end
    assert (stall_cnt === exp_s) else begin
      n_err++;
      $error("FAIL stall_cnt vec=%0d: observed %0d expected %0d", n_vec, stall_cnt, exp_s);
    end
    assert (flush_cnt === exp_f) else begin
      n_err++;
      $error("FAIL flush_cnt vec=%0d: observed %0d expected %0d", n_vec, flush_cnt, exp_f);
    end
    @(posedge CLK);
    if (act == A_RESET) begin
      m_wait = 1'b0;
      m_halt = 1'b0;
      m_scnt = 32'd0;
      m_fcnt = 32'd0;
    end else begin
      if (!exp_v[7] && !m_halt) m_scnt = m_scnt + 32'd1;
      if (exp_v[5]) m_fcnt = m_fcnt + 32'd1;
      if (act == A_HALT) begin
        m_halt = 1'b1;
        m_wait = 1'b0;
      end else if (act == A_STALL) begin
        m_wait = 1'b1;
      end else if (act != A_HALTED) begin
        m_wait = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0; ifid_rt_used = 1'b0;
    idex_dREN = 1'b0; ex_redirect = 1'b0; exmem_dREN = 1'b0;
    exmem_dWEN = 1'b0; exmem_halt = 1'b0;
    ifid_rs = 5'd1; ifid_rt = 5'd2; idex_wsel = 5'd3;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    step(); step();
    // normal flow
    idle();
    for (int i = 0; i < 5; i++) step();
    // data-cache wait for 3 cycles then hit
    exmem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) step();
    dhit = 1'b1; step();
    idle(); step();
    // load-use on rs, then clear
    idex_dREN = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8; step();
    idex_dREN = 1'b0; step();
    // load to r0: no stall
    idex_dREN = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0; step();
    // load-use on rt only when rt is a source
    idle(); idex_dREN = 1'b1; idex_wsel = 5'd9; ifid_rt = 5'd9; step();
    ifid_rt_used = 1'b1; step();
    // redirect with ihit=0 and load-use
    idle(); ex_redirect = 1'b1; ihit = 1'b0;
    idex_dREN = 1'b1; idex_wsel = 5'd4; ifid_rs = 5'd4; step();
    // icache miss two cycles
    idle(); ihit = 1'b0; step(); step();
    // halt with simultaneous dreq: halt wins, then stays halted
    idle(); exmem_halt = 1'b1; exmem_dWEN = 1'b1; step();
    idle(); for (int i = 0; i < 3; i++) step();
    RST = 1'b1; step();
    idle(); step();
    // randomized phase
    for (int i = 0; i < 400; i++) begin
      RST          = ($urandom_range(0, 49) == 0);
      ihit         = ($urandom_range(0, 3) != 0);
      dhit         = $urandom_range(0, 1);
      exmem_dREN   = ($urandom_range(0, 4) == 0);
      exmem_dWEN   = ($urandom_range(0, 6) == 0);
      exmem_halt   = ($urandom_range(0, 39) == 0);
      ex_redirect  = ($urandom_range(0, 5) == 0);
      idex_dREN    = ($urandom_range(0, 2) == 0);
      ifid_rt_used = $urandom_range(0, 1);
      idex_wsel    = 5'($urandom_range(0, 3));
      ifid_rs      = 5'($urandom_range(0, 3));
      ifid_rt      = 5'($urandom_range(0, 3));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
